// File: rtl/cal_pulse_pkg.sv
// Shared constants and types for the multi-channel calibration pulse generator:
// register map, CTRL bit positions and the per-channel state encoding.
package cal_pulse_pkg;

    localparam int REG_CTRL   = 'h00;
    localparam int REG_ENABLE = 'h04;
    localparam int REG_STATUS = 'h08;
    localparam int REG_ID     = 'h0C;
    localparam int CH_BASE    = 'h10;
    localparam int CH_STRIDE  = 'h10;

    // Word offsets inside one channel block.
    localparam logic [1:0] CH_OFF_DELAY  = 2'd0;
    localparam logic [1:0] CH_OFF_WIDTH  = 2'd1;
    localparam logic [1:0] CH_OFF_PERIOD = 2'd2;
    localparam logic [1:0] CH_OFF_COUNT  = 2'd3;

    localparam logic [31:0] ID_VALUE = 32'h0002_0000;

    localparam int CTRL_SW_TRIG_BIT = 0;
    localparam int CTRL_ABORT_BIT   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DLY  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } chan_state_e;

endpackage

// File: rtl/cal_pulse_multi_if.sv
// Word-addressed configuration port that sits behind the AXI4-Lite slave shim.
interface cal_pulse_multi_if #(
    parameter int ADDR_W = 8
) ();
    logic              cfg_wr_en;
    logic              cfg_rd_en;
    logic [ADDR_W-1:0] cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [31:0]       cfg_rdata;
    logic              cfg_rd_valid;

    modport master (
        output cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wdata,
        input  cfg_rdata, cfg_rd_valid
    );

    modport slave (
        input  cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wdata,
        output cfg_rdata, cfg_rd_valid
    );
endinterface

// File: rtl/cal_pulse_chan.sv
// One calibration channel: shadow registers captured at trigger, delay/high/low
// counters and the IDLE -> DLY -> HIGH -> LOW sequencer.
module cal_pulse_chan
    import cal_pulse_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             i_trig,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_dly,
    input  logic [CNT_W-1:0] i_wid,
    input  logic [CNT_W-1:0] i_per,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_done
);

    chan_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_tmr, w_tmr_nxt;
    logic [CNT_W-1:0] r_pcnt, w_pcnt_nxt, w_pcnt_inc;
    logic [CNT_W-1:0] r_s_dly, r_s_wid, r_s_low, r_s_cnt;
    logic [CNT_W-1:0] w_wid_eff, w_low_eff;
    logic             r_done, w_done_nxt, w_load;

    // Width/low-phase clamping is resolved once at capture so the terminal
    // compares below are plain equality against the shadows.
    assign w_wid_eff  = (i_wid == '0) ? CNT_W'(1) : i_wid;
    assign w_low_eff  = (i_per <= w_wid_eff) ? CNT_W'(1) : i_per - w_wid_eff;
    assign w_pcnt_inc = (r_pcnt == '1) ? r_pcnt : r_pcnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_pcnt_nxt  = r_pcnt;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        if (i_stop) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_trig) begin
                        w_load      = 1'b1;
                        w_tmr_nxt   = CNT_W'(1);
                        w_pcnt_nxt  = '0;
                        w_state_nxt = (i_dly == '0) ? HIGH : DLY;
                    end
                end
                DLY: begin
                    if (r_tmr == r_s_dly) begin
                        w_state_nxt = HIGH;
                        w_tmr_nxt   = CNT_W'(1);
                    end else begin
                        w_tmr_nxt = r_tmr + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (r_tmr == r_s_wid) begin
                        w_tmr_nxt = CNT_W'(1);
                        if ((r_s_cnt != '0) && (w_pcnt_inc == r_s_cnt)) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = LOW;
                            w_pcnt_nxt  = w_pcnt_inc;
                        end
                    end else begin
                        w_tmr_nxt = r_tmr + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (r_tmr == r_s_low) begin
                        w_state_nxt = HIGH;
                        w_tmr_nxt   = CNT_W'(1);
                    end else begin
                        w_tmr_nxt = r_tmr + CNT_W'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= IDLE;
            r_tmr   <= '0;
            r_pcnt  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_s_dly <= '0;
            r_s_wid <= CNT_W'(1);
            r_s_low <= CNT_W'(1);
            r_s_cnt <= CNT_W'(1);
        end else if (w_load) begin
            r_s_dly <= i_dly;
            r_s_wid <= w_wid_eff;
            r_s_low <= w_low_eff;
            r_s_cnt <= i_cnt;
        end
    end

    assign o_pulse = (r_state == HIGH);
    assign o_busy  = (r_state != IDLE);
    assign o_done  = r_done;

endmodule

// File: rtl/cal_pulse_multi.sv
// Multi-channel calibration pulse generator: register file, trigger/abort logic
// and N_CH channel sequencers. Define CAL_PULSE_EXT_TRIG_SYNC_EN to resynchronise ext_trig.
module cal_pulse_multi
    import cal_pulse_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic               ACLK,
    input  logic               ARESET,
    cal_pulse_multi_if.slave   cfg,
    input  logic               ext_trig,
    output logic [N_CH-1:0]    pulse_out,
    output logic [N_CH-1:0]    busy,
    output logic [N_CH-1:0]    done_pulse
);

    logic [CNT_W-1:0]  r_dly [N_CH];
    logic [CNT_W-1:0]  r_wid [N_CH];
    logic [CNT_W-1:0]  r_per [N_CH];
    logic [CNT_W-1:0]  r_cnt [N_CH];
    logic [N_CH-1:0]   r_en;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_off;
    logic [N_CH-1:0]   w_ch_sel;
    logic              w_hit_ctrl, w_hit_en, w_hit_stat, w_hit_id;
    logic              w_sw, w_abort, w_ext_in, w_ext_rise;
    logic              r_ext_d, r_trig, r_abort;
    logic [31:0]       w_rd_mux, r_rdata;
    logic              r_rd_valid;
    logic              w_unused;

    assign w_unused = ^{cfg.cfg_addr[1:0], cfg.cfg_wdata[31:CNT_W]};

    assign w_addr     = {cfg.cfg_addr[ADDR_W-1:2], 2'b00};
    assign w_off      = cfg.cfg_addr[3:2];
    assign w_hit_ctrl = (w_addr == ADDR_W'(REG_CTRL));
    assign w_hit_en   = (w_addr == ADDR_W'(REG_ENABLE));
    assign w_hit_stat = (w_addr == ADDR_W'(REG_STATUS));
    assign w_hit_id   = (w_addr == ADDR_W'(REG_ID));

    always_comb begin
        w_ch_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_ch_sel[c] = (w_addr >= ADDR_W'(CH_BASE + c * CH_STRIDE)) &&
                          (w_addr <  ADDR_W'(CH_BASE + (c + 1) * CH_STRIDE));
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_en <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_dly[c] <= '0;
                r_wid[c] <= CNT_W'(1);
                r_per[c] <= CNT_W'(2);
                r_cnt[c] <= CNT_W'(1);
            end
        end else if (cfg.cfg_wr_en) begin
            if (w_hit_en) r_en <= cfg.cfg_wdata[N_CH-1:0];
            for (int c = 0; c < N_CH; c++) begin
                if (w_ch_sel[c]) begin
                    unique case (w_off)
                        CH_OFF_DELAY:  r_dly[c] <= cfg.cfg_wdata[CNT_W-1:0];
                        CH_OFF_WIDTH:  r_wid[c] <= cfg.cfg_wdata[CNT_W-1:0];
                        CH_OFF_PERIOD: r_per[c] <= cfg.cfg_wdata[CNT_W-1:0];
                        default:       r_cnt[c] <= cfg.cfg_wdata[CNT_W-1:0];
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_hit_en)   w_rd_mux = 32'(r_en);
        if (w_hit_stat) w_rd_mux = 32'(busy);
        if (w_hit_id)   w_rd_mux = ID_VALUE;
        for (int c = 0; c < N_CH; c++) begin
            if (w_ch_sel[c]) begin
                unique case (w_off)
                    CH_OFF_DELAY:  w_rd_mux = 32'(r_dly[c]);
                    CH_OFF_WIDTH:  w_rd_mux = 32'(r_wid[c]);
                    CH_OFF_PERIOD: w_rd_mux = 32'(r_per[c]);
                    default:       w_rd_mux = 32'(r_cnt[c]);
                endcase
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd_valid <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_rd_valid <= cfg.cfg_rd_en;
            if (cfg.cfg_rd_en) r_rdata <= w_rd_mux;
        end
    end

    assign cfg.cfg_rdata    = r_rdata;
    assign cfg.cfg_rd_valid = r_rd_valid;

`ifdef CAL_PULSE_EXT_TRIG_SYNC_EN
    logic r_ext_s1, r_ext_s2;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_ext_s1 <= 1'b0;
            r_ext_s2 <= 1'b0;
        end else begin
            r_ext_s1 <= ext_trig;
            r_ext_s2 <= r_ext_s1;
        end
    end

    assign w_ext_in = r_ext_s2;
`else
    assign w_ext_in = ext_trig;
`endif

    assign w_ext_rise = w_ext_in & ~r_ext_d;
    assign w_sw       = cfg.cfg_wr_en & w_hit_ctrl & cfg.cfg_wdata[CTRL_SW_TRIG_BIT];
    assign w_abort    = cfg.cfg_wr_en & w_hit_ctrl & cfg.cfg_wdata[CTRL_ABORT_BIT];

    // Abort masks any trigger arriving in the same cycle, whatever its source.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_ext_d <= 1'b0;
            r_trig  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_ext_d <= w_ext_in;
            r_trig  <= (w_sw | w_ext_rise) & ~w_abort;
            r_abort <= w_abort;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        cal_pulse_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .ACLK    (ACLK),
            .ARESET  (ARESET),
            .i_trig  (r_trig & r_en[c]),
            .i_stop  (r_abort | ~r_en[c]),
            .i_dly   (r_dly[c]),
            .i_wid   (r_wid[c]),
            .i_per   (r_per[c]),
            .i_cnt   (r_cnt[c]),
            .o_pulse (pulse_out[c]),
            .o_busy  (busy[c]),
            .o_done  (done_pulse[c])
        );
    end

endmodule

// File: doc/cal_pulse_multi.md
Name: cal_pulse_multi

Overview:
- Next-generation calibration pulse generator for the tracker front-end.
- Drives N_CH independent calibration pulse outputs, each with its own delay, width, period and repeat count.
- Pulse trains start on a software trigger or an external trigger.
- Configured through a simple word-addressed register port that sits behind the existing AXI4-Lite slave shim in the block design.

Parameters:
N_CH, 4, number of pulse channels (1..12).
CNT_W, 16, width of the delay, width, period and count fields.
ADDR_W, 8, register byte-address width.

Ports:
ACLK  in  1  system clock; all logic on the rising edge.
ARESET  in  1  asynchronous, active-high reset.
cfg_wr_en  in  1  register write strobe, one cycle.
cfg_rd_en  in  1  register read strobe, one cycle.
cfg_addr  in  ADDR_W  byte address, word aligned; bits [1:0] ignored.
cfg_wdata  in  32  write data.
cfg_rdata  out  32  read data.
cfg_rd_valid  out  1  read data valid.
ext_trig  in  1  external trigger; rising edge starts enabled channels.
pulse_out  out  N_CH  calibration pulse per channel.
busy  out  N_CH  channel sequence in progress.
done_pulse  out  N_CH  one-cycle strobe when a channel finishes its sequence.

Behaviour:
- Register map:
  - 0x00 CTRL (write-only, self-clearing): bit0 sw_trig, bit1 abort.
  - 0x04 ENABLE [N_CH-1:0] (R/W).
  - 0x08 STATUS = busy (read-only).
  - 0x0C ID, reads 0x0002_0000.
  - Channel c registers start at 0x10+0x10*c: +0 DELAY, +4 WIDTH, +8 PERIOD, +C COUNT. All are R/W, CNT_W bits, zero-extended on read.
- Reset values: DELAY 0, WIDTH 1, PERIOD 2, COUNT 1, ENABLE 0.
- All outputs reset to 0, including cfg_rdata and cfg_rd_valid.
- Register reads:
  - cfg_rd_valid is high exactly one cycle after cfg_rd_en, with cfg_rdata valid in that cycle.
  - Unmapped addresses read 0 and ignore writes.
- Trigger: trig = sw_trig write OR rising edge of ext_trig. Simultaneous sources count as one trigger.
- A trigger starts every channel whose ENABLE bit is set and which is in IDLE. Busy channels ignore the trigger.
- Shadowing: DELAY, WIDTH, PERIOD and COUNT are captured into shadow registers on the trigger cycle. Writes during a sequence take effect at the next trigger.
- Per-channel state machine: IDLE -> DLY -> HIGH -> LOW -> HIGH ... -> IDLE.
  - Trigger accepted at edge T.
  - pulse_out goes high at edge T+1+DELAY and stays high WIDTH cycles.
  - pulse_out then stays low for PERIOD-WIDTH cycles before the next pulse.
  - DELAY=0 skips DLY.
- Width and period rules:
  - WIDTH=0 is treated as 1.
  - PERIOD<=WIDTH gives a low phase of 1 cycle.
  - Counters are CNT_W bits and never wrap. Terminal comparisons use the shadow values.
- Count and completion:
  - COUNT=0 means continuous until abort or ENABLE cleared.
  - Otherwise exactly COUNT pulses are produced.
  - The last HIGH phase returns to IDLE directly, with no trailing low phase.
  - done_pulse strobes, and busy falls, on the cycle after the last high cycle.
- busy is high from T+1 until return to IDLE.
- Abort or clearing a channel's ENABLE bit:
  - The channel goes to IDLE on the next edge and pulse_out goes low.
  - No done_pulse is issued.
  - Abort wins over a trigger in the same write and over an external trigger in the same cycle.
- ARESET mid-sequence: immediate return to IDLE, all registers back to reset values.

Optional Feature:
CAL_PULSE_EXT_TRIG_SYNC_EN
- Defined: ext_trig passes through a 2-flop synchroniser before rising-edge detection. External trigger latency grows by 2 cycles.
- Undefined: ext_trig is treated as synchronous to ACLK and goes straight into a 1-flop edge detector.

Decomposition:
- cal_pulse_pkg holds:
  - register offset constants, channel stride 0x10 and ID value;
  - the channel state enum (IDLE, DLY, HIGH, LOW);
  - the CTRL bit indices.
- Sub-module cal_pulse_chan holds one channel's state machine, shadow registers and counters. It is generated N_CH times; the top level owns the register file and the trigger logic.

Test Plan:
- Default config, ENABLE=0x1, sw_trig at T -> pulse_out[0] high at T+1 for 1 cycle; done_pulse[0] at T+2; STATUS reads 0 afterwards.
- Ch1 DELAY=3, WIDTH=2, PERIOD=5, COUNT=2, ENABLE=0x2, sw_trig at T -> pulse_out[1] high during T+4..T+5 and T+9..T+10; busy[1] falls and done_pulse[1] strobes at T+11.
- Ch0 COUNT=0, PERIOD=4, WIDTH=1 -> continuous 1-of-4 pulses; abort at cycle A -> pulse_out[0]=0 and busy[0]=0 from A+1; no done_pulse.
- Ch2 running; rewrite WIDTH=7 mid-sequence and issue a second trigger -> the current sequence keeps the old width and the trigger is ignored; the next trigger after done uses WIDTH=7.
- ext_trig rising edge together with sw_trig, ENABLE=0xF -> all channels start once; measured latency is 1+DELAY, plus 2 cycles with CAL_PULSE_EXT_TRIG_SYNC_EN for an external-only trigger.
- Read 0x0C -> 0x0002_0000 with cfg_rd_valid one cycle later; read 0xFC -> 0; ARESET asserted mid-pulse -> all outputs 0 and DELAY reads 0.
